// File: rtl/calc_pkg.sv
// Shared types and constants for the four-digit BCD calculator sequencer.
package calc_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        ENTRY_B = 3'd1,
        COMPUTE = 3'd2,
        RESULT  = 3'd3,
        PASS2   = 3'd4
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam bcd_t       BCD_MAX   = 4'd9;
    localparam logic [4:0] BCD_RADIX = 5'd10;

    // PASS2 is a second subtract pass, so it reports the same LED code as COMPUTE.
    function automatic logic [1:0] state_mode(input state_t s);
        logic [1:0] m;
        case (s)
            ENTRY_A: m = 2'd0;
            ENTRY_B: m = 2'd1;
            COMPUTE: m = 2'd2;
            PASS2:   m = 2'd2;
            RESULT:  m = 2'd3;
            default: m = 2'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// Combinational single-digit BCD adder/subtractor with carry/borrow in and out.
module bcd_digit_alu
    import calc_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    input  op_t  op,
    output bcd_t r,
    output logic cout
);

    logic [4:0] sum_s;
    logic [4:0] need_s;

    // For subtract, cout is the borrow out and the digit is corrected by +10.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        need_s = {1'b0, b} + {4'd0, cin};
        r      = 4'd0;
        cout   = 1'b0;
        case (op)
            OP_ADD: begin
                if (sum_s > {1'b0, BCD_MAX}) begin
                    r    = 4'(sum_s - BCD_RADIX);
                    cout = 1'b1;
                end else begin
                    r    = sum_s[3:0];
                    cout = 1'b0;
                end
            end
            OP_SUB: begin
                if ({1'b0, a} < need_s) begin
                    r    = 4'({1'b0, a} + BCD_RADIX - need_s);
                    cout = 1'b1;
                end else begin
                    r    = 4'({1'b0, a} - need_s);
                    cout = 1'b0;
                end
            end
            default: begin
                r    = 4'd0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: digit entry, operand capture and digit-serial BCD
// add/subtract with a second reversed pass to produce a negative magnitude.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr_pulse,
    input  logic                      ent_pulse,
    input  logic [NUM_DIGITS-1:0]     digit_inc,
    input  logic                      arith_sel,
    output logic [4*NUM_DIGITS-1:0]   disp_bcd,
    output logic                      neg,
    output logic                      ovf,
    output logic                      busy,
    output logic                      result_valid,
    output logic [1:0]                mode
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_DIGITS - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] entry_q, entry_d;
    logic [DW-1:0] op_a_q, op_a_d;
    logic [DW-1:0] op_b_q, op_b_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] disp_q, disp_d;
    logic [KW-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          rv_q, rv_d;
    logic [1:0]    mode_q, mode_d;
    op_t           op_latched_q, op_latched_d;
    logic          arith_prev_q, arith_prev_d;

    bcd_t          alu_a_s, alu_b_s, alu_r_s;
    logic          alu_cout_s;
    op_t           alu_op_s;

    // Each pulsed digit wraps 9 -> 0 on its own; no carry into the next digit.
    function automatic logic [DW-1:0] inc_digits(input logic [DW-1:0] v,
                                                 input logic [NUM_DIGITS-1:0] m);
        logic [DW-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (m[i]) begin
                r[4*i +: 4] = (v[4*i +: 4] >= BCD_MAX) ? 4'd0 : v[4*i +: 4] + 4'd1;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Select digit k into the ALU; PASS2 swaps operands to form b - a.
    always_comb begin
        if (state_q == PASS2) begin
            alu_a_s  = op_b_q[{k_q, 2'b00} +: 4];
            alu_b_s  = op_a_q[{k_q, 2'b00} +: 4];
            alu_op_s = OP_SUB;
        end else begin
            alu_a_s  = op_a_q[{k_q, 2'b00} +: 4];
            alu_b_s  = op_b_q[{k_q, 2'b00} +: 4];
            alu_op_s = op_latched_q;
        end
    end

    bcd_digit_alu u_alu (
        .a    (alu_a_s),
        .b    (alu_b_s),
        .cin  (carry_q),
        .op   (alu_op_s),
        .r    (alu_r_s),
        .cout (alu_cout_s)
    );

    // Next-state and datapath updates; clear has priority over everything else.
    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        k_d          = k_q;
        carry_d      = carry_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;
        op_latched_d = op_latched_q;
        arith_prev_d = arith_prev_q;

        if (clr_pulse) begin
            state_d      = ENTRY_A;
            entry_d      = {DW{1'b0}};
            op_a_d       = {DW{1'b0}};
            op_b_d       = {DW{1'b0}};
            result_d     = {DW{1'b0}};
            k_d          = {KW{1'b0}};
            carry_d      = 1'b0;
            neg_d        = 1'b0;
            ovf_d        = 1'b0;
            op_latched_d = OP_ADD;
            arith_prev_d = 1'b0;
        end else begin
            case (state_q)
                ENTRY_A: begin
                    if (ent_pulse) begin
                        op_a_d  = entry_q;
                        entry_d = {DW{1'b0}};
                        state_d = ENTRY_B;
                    end else begin
                        entry_d = inc_digits(entry_q, digit_inc);
                    end
                end
                ENTRY_B: begin
                    if (ent_pulse) begin
                        op_b_d       = entry_q;
                        op_latched_d = op_t'(arith_sel);
                        arith_prev_d = arith_sel;
                        k_d          = {KW{1'b0}};
                        carry_d      = 1'b0;
                        state_d      = COMPUTE;
                    end else begin
                        entry_d = inc_digits(entry_q, digit_inc);
                    end
                end
                COMPUTE, PASS2: begin
                    result_d[{k_q, 2'b00} +: 4] = alu_r_s;
                    carry_d = alu_cout_s;
                    k_d     = k_q + KW'(1'b1);
                    if (k_q == K_LAST) begin
                        k_d = {KW{1'b0}};
                        if (state_q == PASS2) begin
                            neg_d   = 1'b1;
                            state_d = RESULT;
                        end else if (op_latched_q == OP_ADD) begin
                            ovf_d   = alu_cout_s;
                            state_d = RESULT;
                        end else if (alu_cout_s) begin
                            // a < b: rerun as b - a to get the magnitude.
                            carry_d = 1'b0;
                            state_d = PASS2;
                        end else begin
                            neg_d   = 1'b0;
                            state_d = RESULT;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                RESULT: begin
                    if (ent_pulse) begin
                        entry_d = {DW{1'b0}};
                        neg_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = ENTRY_A;
                    end else if (arith_sel != arith_prev_q) begin
                        op_latched_d = op_t'(arith_sel);
                        arith_prev_d = arith_sel;
                        neg_d        = 1'b0;
                        ovf_d        = 1'b0;
                        k_d          = {KW{1'b0}};
                        carry_d      = 1'b0;
                        state_d      = COMPUTE;
                    end else begin
                        state_d = RESULT;
                    end
                end
                default: begin
                    state_d = ENTRY_A;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_comb begin
        busy_d = (state_d == COMPUTE) || (state_d == PASS2);
        mode_d = state_mode(state_d);
        rv_d   = (state_d == RESULT) && (state_q != RESULT);
        case (state_d)
            ENTRY_A, ENTRY_B: disp_d = entry_d;
            RESULT:           disp_d = result_d;
            default:          disp_d = disp_q;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ENTRY_A;
            entry_q      <= {DW{1'b0}};
            op_a_q       <= {DW{1'b0}};
            op_b_q       <= {DW{1'b0}};
            result_q     <= {DW{1'b0}};
            disp_q       <= {DW{1'b0}};
            k_q          <= {KW{1'b0}};
            carry_q      <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            rv_q         <= 1'b0;
            mode_q       <= 2'd0;
            op_latched_q <= OP_ADD;
            arith_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            disp_q       <= disp_d;
            k_q          <= k_d;
            carry_q      <= carry_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
            rv_q         <= rv_d;
            mode_q       <= mode_d;
            op_latched_q <= op_latched_d;
            arith_prev_q <= arith_prev_d;
        end
    end

    assign disp_bcd     = disp_q;
    assign neg          = neg_q;
    assign ovf          = ovf_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign mode         = mode_q;

endmodule
